// File: rtl/norm_shifter.sv
// Leading-zero normalizer: five fixed stages (16/8/4/2/1) shift the operand left
// until bit 31 is set, accumulating the shift amount; fixed 5-cycle latency.
module norm_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z,
    output logic [4:0]  cnt,
    output logic        zero
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] w;
    logic [4:0]  c;
    logic [2:0]  s;
    logic        flag;

    logic        hit;
    logic [31:0] w_sh;
    logic [4:0]  k;

    // Stage select: test the top k bits and prepare the k-bit shifted word.
    always_comb begin
        hit  = 1'b0;
        w_sh = w;
        k    = 5'd0;
        case (s)
            3'd0: begin hit = (w[31:16] == 16'd0); w_sh = {w[15:0], 16'd0}; k = 5'd16; end
            3'd1: begin hit = (w[31:24] == 8'd0);  w_sh = {w[23:0], 8'd0};  k = 5'd8;  end
            3'd2: begin hit = (w[31:28] == 4'd0);  w_sh = {w[27:0], 4'd0};  k = 5'd4;  end
            3'd3: begin hit = (w[31:30] == 2'd0);  w_sh = {w[29:0], 2'd0};  k = 5'd2;  end
            3'd4: begin hit = ~w[31];              w_sh = {w[30:0], 1'b0};  k = 5'd1;  end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: if (s == 3'd4) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            w     <= 32'd0;
            c     <= 5'd0;
            s     <= 3'd0;
            flag  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    w    <= a;
                    c    <= 5'd0;
                    s    <= 3'd0;
                    flag <= (a == 32'd0);
                end
                SHIFT: begin
                    s <= s + 3'd1;
                    if (hit) begin
                        w <= w_sh;
                        c <= c + k;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result fields come straight from the working registers.
    assign z    = w;
    assign cnt  = c;
    assign zero = flag;

endmodule

// File: doc/norm_shifter.md
NORM_SHIFTER -- requirements
Module: norm_shifter

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits, count width fixed at 5 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operand offered on a.
REQ-005 in_ready  output  1  block can accept an operand.
REQ-006 a  input  32  unsigned operand to normalize.
REQ-007 out_valid  output  1  result on z/cnt/zero is valid.
REQ-008 out_ready  input  1  consumer accepts result.
REQ-009 z  output  32  normalized value: a shifted left until bit 31 = 1.
REQ-010 cnt  output  5  left-shift amount applied, equal to the leading-zero count of a.
REQ-011 zero  output  1  set when a == 0.

Function
REQ-012 Block is the inverse companion of the 5-stage left/right barrel shifter: it derives the shift amount from the data and applies it; z == a << cnt always holds.
REQ-013 FSM states: IDLE, SHIFT, DONE; exactly one active.
REQ-014 IDLE: in_ready=1, out_valid=0; on in_valid && in_ready edge, working reg W <= a, count C <= 0, stage counter S <= 0, zero flag <= (a == 0), go to SHIFT.
REQ-015 SHIFT: in_ready=0, out_valid=0; one stage per cycle, shift size k = 16, 8, 4, 2, 1 for S = 0..4.
REQ-016 Per stage: if W[31:32-k] all zero -> W <= W << k (zero fill) and C <= C + k; else W, C unchanged.
REQ-017 After stage S=4 edge, go to DONE; C never exceeds 31, so no overflow handling is needed.
REQ-018 Fixed latency: acceptance at edge N, stages at edges N+1..N+5, out_valid=1 after edge N+5, independent of data.
REQ-019 DONE: out_valid=1, in_ready=0; z=W, cnt=C, zero=flag held stable until out_valid && out_ready edge, then go to IDLE.
REQ-020 No new operand accepted in SHIFT or DONE; in_valid there is ignored and a is not sampled.
REQ-021 out_ready has no effect outside DONE.
REQ-022 a == 0: all stages shift, result z=0x00000000, cnt=31, zero=1.
REQ-023 a[31]=1: no stage shifts, z=a, cnt=0, zero=0.
REQ-024 Minimum throughput: one result per 7 cycles (accept, 5 stages, hand-off with out_ready=1).
REQ-025 Outputs z, cnt, zero are registered; no combinational path from a or in_valid to any output, and none from out_ready to in_ready.

Reset
REQ-026 rst=1 asynchronously forces IDLE, W=0, C=0, S=0, flag=0, so z=0, cnt=0, zero=0, out_valid=0, in_ready=1.
REQ-027 rst asserted mid-SHIFT or in DONE aborts the operation; partial result is discarded and never presented.
REQ-028 After rst deassertion, first acceptance is possible on the first rising edge with in_valid=1.

Verification
REQ-029 a=0x00000001, out_ready=1 -> after 5 stage cycles z=0x80000000, cnt=31, zero=0.
REQ-030 a=0x80000000 -> z=0x80000000, cnt=0, zero=0; out_valid at the same latency as other operands (edge N+5).
REQ-031 a=0x00012345 -> z=0x91A28000, cnt=15, zero=0.
REQ-032 a=0x00000000 -> z=0x00000000, cnt=31, zero=1.
REQ-033 Backpressure: out_ready held 0 for 3 cycles in DONE with in_valid=1 and a changing -> z/cnt/zero stable, in_ready=0, no new operand accepted; result consumed on first out_ready=1 edge, in_ready=1 next cycle.
REQ-034 Reset mid-op: assert rst during stage S=2 -> out_valid=0, in_ready=1, z=0, cnt=0 immediately; next operand a=0x00F00000 yields z=0xF0000000, cnt=8.
